// File: rtl/alu_pkg.sv
// Shared codes for the ALU/multiply-divide control slice:
// aluop classes, R-type funct values, ALU configurations and engine states.
package alu_pkg;

  localparam logic [2:0] OP_LWSW  = 3'b000;
  localparam logic [2:0] OP_BR    = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_ANDI  = 3'b011;
  localparam logic [2:0] OP_SLTI  = 3'b100;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;

  localparam logic [3:0] C_AND = 4'd0;
  localparam logic [3:0] C_OR  = 4'd1;
  localparam logic [3:0] C_ADD = 4'd2;
  localparam logic [3:0] C_SUB = 4'd3;
  localparam logic [3:0] C_SLT = 4'd4;
  localparam logic [3:0] C_NOR = 4'd5;
  localparam logic [3:0] C_XOR = 4'd6;
  localparam logic [3:0] C_SLL = 4'd7;
  localparam logic [3:0] C_SRL = 4'd8;
  localparam logic [3:0] C_SRA = 4'd9;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide engine: magnitudes in, one shift-add or
// restoring-subtract step per cycle, sign fix-up in the final state.
module md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             is_div_q, is_div_d;
  logic             nprod_q, nprod_d;
  logic             nrem_q, nrem_d;
  logic             dbz_q, dbz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rsh;
  logic             ge;
  logic [WIDTH-1:0] sub;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;

  assign a_neg = i_signed & i_a[WIDTH-1];
  assign b_neg = i_signed & i_b[WIDTH-1];
  assign a_mag = a_neg ? -i_a : i_a;
  assign b_mag = b_neg ? -i_b : i_b;

  assign addend = lo_q[0] ? opb_q : {WIDTH{1'b0}};
  assign sum    = {1'b0, acc_q} + {1'b0, addend};
  assign rsh    = {acc_q, lo_q[WIDTH-1]};
  assign ge     = rsh >= {1'b0, opb_q};
  // Partial remainder fits in WIDTH bits whenever the subtract is taken.
  assign sub    = rsh[WIDTH-1:0] - opb_q;

  assign prod   = {acc_q, lo_q};
  assign prod_s = nprod_q ? -prod : prod;
  assign quo_s  = nprod_q ? -lo_q : lo_q;
  assign rem_s  = nrem_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    dvd_d    = dvd_q;
    is_div_d = is_div_q;
    nprod_d  = nprod_q;
    nrem_d   = nrem_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      MD_IDLE: begin
        if (i_start && !i_flush) begin
          state_d  = MD_CALC;
          cnt_d    = CW'(WIDTH);
          acc_d    = '0;
          lo_d     = a_mag;
          opb_d    = b_mag;
          dvd_d    = i_a;
          is_div_d = i_is_div;
          nprod_d  = a_neg ^ b_neg;
          nrem_d   = a_neg;
          dbz_d    = i_is_div & ~|i_b;
        end
      end
      MD_CALC: begin
        if (is_div_q) begin
          acc_d = ge ? sub : rsh[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], ge};
        end else begin
          acc_d = sum[WIDTH:1];
          lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = MD_FIX;
      end
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (i_flush && state_q != MD_IDLE) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      dvd_q    <= '0;
      is_div_q <= 1'b0;
      nprod_q  <= 1'b0;
      nrem_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      dvd_q    <= dvd_d;
      is_div_q <= is_div_d;
      nprod_q  <= nprod_d;
      nrem_q   <= nrem_d;
      dbz_q    <= dbz_d;
    end
  end

  assign o_busy = state_q != MD_IDLE;
  assign o_done = (state_q == MD_FIX) & ~i_flush;
  assign o_hi   = is_div_q ? (dbz_q ? dvd_q : rem_s)
                           : prod_s[2*WIDTH-1:WIDTH];
  assign o_lo   = is_div_q ? (dbz_q ? {WIDTH{1'b1}} : quo_s)
                           : prod_s[WIDTH-1:0];

endmodule

// File: rtl/alu_md_control.sv
// EX-stage ALU control decode plus HI/LO registers fronting the
// iterative multiply/divide engine, with stall generation.
module alu_md_control
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_aluop,
  input  logic [5:0]       i_funct,
  input  logic             i_valid,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  output logic [3:0]       o_aluconf,
  output logic             o_sign,
  output logic             o_busy,
  output logic             o_stall,
  output logic [WIDTH-1:0] o_hilo_rdata
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic             md_done, busy;
  logic             rv, is_md, is_hilo;
  logic             md_start, md_div, md_signed;
  logic             mt_ok;

  assign rv      = i_valid & (i_aluop == OP_RTYPE);
  assign is_md   = i_funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  assign is_hilo = i_funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO};

  assign md_start  = rv & is_md & ~i_flush & ~busy;
  assign md_div    = (i_funct == F_DIV) | (i_funct == F_DIVU);
  assign md_signed = (i_funct == F_MULT) | (i_funct == F_DIV);
  assign mt_ok     = rv & ~busy & ~i_flush;

  always_comb begin
    o_aluconf = C_ADD;
    case (i_aluop)
      OP_BR:   o_aluconf = C_SUB;
      OP_ANDI: o_aluconf = C_AND;
      OP_SLTI: o_aluconf = C_SLT;
      OP_RTYPE: begin
        case (i_funct)
          F_ADD, F_ADDU: o_aluconf = C_ADD;
          F_SUB, F_SUBU: o_aluconf = C_SUB;
          F_AND:         o_aluconf = C_AND;
          F_OR:          o_aluconf = C_OR;
          F_XOR:         o_aluconf = C_XOR;
          F_NOR:         o_aluconf = C_NOR;
          F_SLT, F_SLTU: o_aluconf = C_SLT;
          F_SLL:         o_aluconf = C_SLL;
          F_SRL:         o_aluconf = C_SRL;
          F_SRA:         o_aluconf = C_SRA;
          default:       o_aluconf = C_ADD;
        endcase
      end
      default: o_aluconf = C_ADD;
    endcase
  end

  assign o_sign = ~((i_aluop == OP_RTYPE) &
    (i_funct inside {F_ADDU, F_SUBU, F_SLTU, F_MULTU, F_DIVU}));

  md_unit #(
    .WIDTH (WIDTH)
  ) u_md (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (md_start),
    .i_is_div (md_div),
    .i_signed (md_signed),
    .i_a      (i_rs),
    .i_b      (i_rt),
    .i_flush  (i_flush),
    .o_busy   (busy),
    .o_done   (md_done),
    .o_hi     (md_hi),
    .o_lo     (md_lo)
  );

  // MT* can never coincide with done: the engine is busy then.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (md_done) begin
      hi_d = md_hi;
      lo_d = md_lo;
    end else begin
      if (mt_ok && i_funct == F_MTHI) hi_d = i_rs;
      if (mt_ok && i_funct == F_MTLO) lo_d = i_rs;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign o_busy  = busy;
  assign o_stall = rv & (is_md | is_hilo) & busy;

  always_comb begin
    o_hilo_rdata = '0;
    if (rv && !busy && i_funct == F_MFHI) o_hilo_rdata = hi_q;
    if (rv && !busy && i_funct == F_MFLO) o_hilo_rdata = lo_q;
  end

endmodule

// File: tb/tb_alu_md_control.sv
// Self-checking bench for alu_md_control: decode sweep, directed and
// random multiply/divide against an arithmetic model, stall/flush/reset.
module tb_alu_md_control;

  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11;
  localparam logic [5:0] MFLO = 6'h12, MTLO = 6'h13;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19;
  localparam logic [5:0] DIV = 6'h1a, DIVU = 6'h1b;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  aluop;
  logic [5:0]  funct;
  logic        valid, flush;
  logic [31:0] rs, rt;
  logic [3:0]  aluconf;
  logic        sign, busy, stall;
  logic [31:0] rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  alu_md_control #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_aluop(aluop), .i_funct(funct),
    .i_valid(valid), .i_flush(flush), .i_rs(rs), .i_rt(rt),
    .o_aluconf(aluconf), .o_sign(sign), .o_busy(busy),
    .o_stall(stall), .o_hilo_rdata(rdata)
  );

  function automatic logic [3:0] exp_conf(logic [2:0] op, logic [5:0] f);
    if (op == 3'b001) return 4'd3;
    if (op == 3'b011) return 4'd0;
    if (op == 3'b100) return 4'd4;
    if (op != 3'b010) return 4'd2;
    case (f)
      6'h20, 6'h21: return 4'd2;
      6'h22, 6'h23: return 4'd3;
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h26: return 4'd6;
      6'h27: return 4'd5;
      6'h2a, 6'h2b: return 4'd4;
      6'h00: return 4'd7;
      6'h02: return 4'd8;
      6'h03: return 4'd9;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic exp_sign(logic [2:0] op, logic [5:0] f);
    if (op != 3'b010) return 1'b1;
    return !(f == 6'h21 || f == 6'h23 || f == 6'h2b ||
             f == 6'h19 || f == 6'h1b);
  endfunction

  task automatic ref_md(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (f == MULT) begin
      sa = longint'(ia);
      sb = longint'(ib);
      sp = sa * sb;
      hi = sp[63:32];
      lo = sp[31:0];
    end else if (f == MULTU) begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      up = ua * ub;
      hi = up[63:32];
      lo = up[31:0];
    end else if (b == 32'd0) begin
      lo = 32'hffffffff;
      hi = a;
    end else if (f == DIV) begin
      if (a == 32'h80000000 && b == 32'hffffffff) begin
        lo = a;
        hi = 32'd0;
      end else begin
        lo = 32'(ia / ib);
        hi = 32'(ia % ib);
      end
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  task automatic start_md(input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
    logic [31:0] h, l;
    @(negedge clk);
    valid = 1'b1; aluop = 3'b010; funct = f; rs = a; rt = b;
    @(posedge clk); #1;
    valid = 1'b0;
    ref_md(f, a, b, h, l);
    m_hi = h;
    m_lo = l;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    valid = 1'b1; aluop = 3'b010; funct = MFHI; #1;
    h = rdata;
    funct = MFLO; #1;
    l = rdata;
    valid = 1'b0;
  endtask

  task automatic write_mt(input logic [5:0] f, input logic [31:0] v);
    @(negedge clk);
    valid = 1'b1; aluop = 3'b010; funct = f; rs = v;
    @(posedge clk); #1;
    valid = 1'b0;
    if (!flush && f == MTHI) m_hi = v;
    if (!flush && f == MTLO) m_lo = v;
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    rst = 1'b1; flush = 1'b0; valid = 1'b1; aluop = 3'b010;
    funct = MFHI; rs = 32'h1; rt = 32'h1;
    #12;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (rdata !== 32'd0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", rdata);
    end
    funct = MULT; #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b want 0", stall);
    end
    valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    read_hilo(h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'd0) begin
      errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", h, l);
    end
  endtask

  task automatic test_decode();
    valid = 1'b0;
    for (int op = 0; op < 8; op++) begin
      for (int f = 0; f < 64; f++) begin
        aluop = op[2:0]; funct = f[5:0]; #1;
        checks++;
        if (aluconf !== exp_conf(op[2:0], f[5:0])) begin
          errors++;
          $display("FAIL decode_conf op=%0d f=%h: got %0d want %0d",
                   op, f, aluconf, exp_conf(op[2:0], f[5:0]));
        end
        checks++;
        if (sign !== exp_sign(op[2:0], f[5:0])) begin
          errors++;
          $display("FAIL decode_sign op=%0d f=%h: got %b want %b",
                   op, f, sign, exp_sign(op[2:0], f[5:0]));
        end
      end
    end
  endtask

  task automatic test_mult();
    logic [31:0] h, l;
    int n;
    start_md(MULT, 32'hfffffffd, 32'd5);
    wait_idle(n);
    read_hilo(h, l);
    checks++;
    if (n !== 33) begin
      errors++; $display("FAIL mult_busy_cycles: got %0d want 33", n);
    end
    checks++;
    if (h !== 32'hffffffff || l !== 32'hfffffff1) begin
      errors++; $display("FAIL mult: got %h/%h want ffffffff/fffffff1", h, l);
    end
    start_md(MULTU, 32'hfffffffd, 32'd5);
    wait_idle(n);
    read_hilo(h, l);
    checks++;
    if (h !== 32'd4 || l !== 32'hfffffff1) begin
      errors++; $display("FAIL multu: got %h/%h want 4/fffffff1", h, l);
    end
  endtask

  task automatic test_div();
    logic [31:0] h, l;
    int n;
    start_md(DIV, 32'hfffffff9, 32'd2);
    wait_idle(n);
    read_hilo(h, l);
    checks++;
    if (h !== 32'hffffffff || l !== 32'hfffffffd) begin
      errors++; $display("FAIL div: got %h/%h want ffffffff/fffffffd", h, l);
    end
    start_md(DIVU, 32'd7, 32'd0);
    wait_idle(n);
    read_hilo(h, l);
    checks++;
    if (n !== 33) begin
      errors++; $display("FAIL divz_busy_cycles: got %0d want 33", n);
    end
    checks++;
    if (h !== 32'd7 || l !== 32'hffffffff) begin
      errors++; $display("FAIL divu_zero: got %h/%h want 7/ffffffff", h, l);
    end
    start_md(DIV, 32'h80000000, 32'hffffffff);
    wait_idle(n);
    read_hilo(h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'h80000000) begin
      errors++; $display("FAIL div_ovf: got %h/%h want 0/80000000", h, l);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    start_md(MULT, $urandom, $urandom);
    repeat (2) begin @(posedge clk); #1; end
    valid = 1'b1; aluop = 3'b010; funct = MFHI; #1;
    while (busy === 1'b1 && n < 200) begin
      checks++;
      if (stall !== 1'b1) begin
        errors++; $display("FAIL stall_held: got %b want 1", stall);
      end
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL stall_release: got %b want 0", stall);
    end
    checks++;
    if (rdata !== m_hi) begin
      errors++; $display("FAIL stall_mfhi: got %h want %h", rdata, m_hi);
    end
    valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] h, l, ea, eb;
    int n = 0;
    ea = $urandom;
    eb = $urandom_range(1, 1000);
    start_md(MULT, $urandom, $urandom);
    valid = 1'b1; aluop = 3'b010; funct = DIVU; rs = ea; rt = eb;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL b2b_stall_idle: got %b want 0", stall);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    ref_md(DIVU, ea, eb, m_hi, m_lo);
    wait_idle(n);
    read_hilo(h, l);
    checks++;
    if (n !== 33) begin
      errors++; $display("FAIL b2b_busy_cycles: got %0d want 33", n);
    end
    checks++;
    if (h !== m_hi || l !== m_lo) begin
      errors++;
      $display("FAIL b2b_result: got %h/%h want %h/%h", h, l, m_hi, m_lo);
    end
  endtask

  task automatic test_flush();
    logic [31:0] h, l, old_hi, old_lo;
    write_mt(MTLO, 32'h12345678);
    old_hi = m_hi;
    old_lo = m_lo;
    start_md(DIV, $urandom, $urandom_range(1, 99));
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle: got busy %b want 0", busy);
    end
    flush = 1'b0;
    m_hi = old_hi;
    m_lo = old_lo;
    read_hilo(h, l);
    checks++;
    if (h !== old_hi || l !== 32'h12345678) begin
      errors++;
      $display("FAIL flush_hilo: got %h/%h want %h/12345678", h, l, old_hi);
    end
    @(negedge clk);
    flush = 1'b1;
    write_mt(MTHI, 32'hdeadbeef);
    start_md(MULT, 32'd3, 32'd3);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_no_start: got busy %b want 0", busy);
    end
    flush = 1'b0;
    m_hi = old_hi;
    m_lo = old_lo;
    read_hilo(h, l);
    checks++;
    if (h !== old_hi || l !== old_lo) begin
      errors++;
      $display("FAIL flush_block: got %h/%h want %h/%h", h, l, old_hi, old_lo);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] h, l;
    write_mt(MTHI, 32'h0badcafe);
    write_mt(MTLO, 32'h55aa55aa);
    start_md(MULT, $urandom, $urandom);
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_busy: got %b want 0", busy);
    end
    @(negedge clk); rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    read_hilo(h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'd0) begin
      errors++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", h, l);
    end
  endtask

  task automatic test_random();
    logic [5:0] f;
    logic [31:0] a, b, h, l;
    int n;
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: f = MULT;
        1: f = MULTU;
        2: f = DIV;
        default: f = DIVU;
      endcase
      a = $urandom;
      b = (i % 3 == 0) ? $urandom_range(1, 300) : $urandom;
      if (i % 5 == 3) b = 32'd0;
      if (i == 6) begin a = 32'h80000000; b = 32'hffffffff; end
      if (i % 2 == 1) a = -a;
      start_md(f, a, b);
      wait_idle(n);
      read_hilo(h, l);
      checks++;
      if (n !== 33) begin
        errors++; $display("FAIL rand_busy_%0d: got %0d want 33", i, n);
      end
      checks++;
      if (h !== m_hi || l !== m_lo) begin
        errors++;
        $display("FAIL rand_%0d f=%h a=%h b=%h: got %h/%h want %h/%h",
                 i, f, a, b, h, l, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_div();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
